// File: rtl/cpu_data_ram_if.sv
`default_nettype none
// ============================================================================
// Module      : cpu_data_ram_if
// Description : Core-to-data-RAM strobe/address/data bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface cpu_data_ram_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 4
);
  logic              ram_EN;
  logic              ram_RW;
  logic [ADDR_W-1:0] ram_address_bus;
  logic [DATA_W-1:0] ram_data_bus_out;
  logic [DATA_W-1:0] ram_data_bus_in;
  logic              rd_valid;
  logic              ready;
  logic              parity_err;

  modport master (
    output ram_EN, ram_RW, ram_address_bus, ram_data_bus_out,
    input  ram_data_bus_in, rd_valid, ready, parity_err
  );

  modport slave (
    input  ram_EN, ram_RW, ram_address_bus, ram_data_bus_out,
    output ram_data_bus_in, rd_valid, ready, parity_err
  );
endinterface
`default_nettype wire

// File: rtl/cpu_data_ram.sv
`default_nettype none
// ============================================================================
// Module      : cpu_data_ram
// Description : Single-port core data RAM with post-reset clear sequence.
//               Optional even-parity storage under macro RAM_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_data_ram #(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 4,
  parameter int CLEAR_VALUE    = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  cpu_data_ram_if.slave     bus
);

  localparam int DEPTH = 1 << ADDR_W;
`ifdef RAM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam logic [DATA_W-1:0] C_CLEAR_WORD = DATA_W'(CLEAR_VALUE);
  localparam state_t            C_RST_STATE  = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

  logic [MEM_W-1:0]  r_mem [DEPTH];
  state_t            r_state;
  logic [ADDR_W-1:0] r_clr_ptr;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rd_valid;
  logic              r_ready;

  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic [MEM_W-1:0]  w_wword;
  logic [MEM_W-1:0]  w_rword;
  logic              w_rd;
  logic              w_perr;

  // The clear sequence owns the write port; core strobes are ignored meanwhile.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = bus.ram_address_bus;
    w_wdata = bus.ram_data_bus_out;
    if (r_state == ST_CLEAR) begin
      w_we    = 1'b1;
      w_waddr = r_clr_ptr;
      w_wdata = C_CLEAR_WORD;
    end else if (bus.ram_EN && bus.ram_RW) begin
      w_we = 1'b1;
    end
  end

  assign w_rd    = (r_state == ST_READY) && bus.ram_EN && !bus.ram_RW;
  assign w_rword = r_mem[bus.ram_address_bus];

`ifdef RAM_PARITY_EN
  // Stored bit makes the ones-count of the whole word even.
  assign w_wword = {^w_wdata, w_wdata};
  assign w_perr  = ^w_rword;
`else
  assign w_wword = w_wdata;
  assign w_perr  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wword;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= C_RST_STATE;
      r_clr_ptr  <= '0;
      r_rdata    <= '0;
      r_rd_valid <= 1'b0;
      r_ready    <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      case (r_state)
        ST_CLEAR: begin
          r_clr_ptr <= r_clr_ptr + ADDR_W'(1);
          if (r_clr_ptr == '1) begin
            r_state <= ST_READY;
            r_ready <= 1'b1;
          end
        end
        ST_READY: begin
          r_ready <= 1'b1;
          if (w_rd) begin
            r_rdata    <= w_rword[DATA_W-1:0];
            r_rd_valid <= 1'b1;
          end
        end
        default: r_state <= C_RST_STATE;
      endcase
    end
  end

`ifdef RAM_PARITY_EN
  logic r_parity_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_parity_err <= 1'b0;
    end else if (w_rd && w_perr) begin
      r_parity_err <= 1'b1;
    end
  end

  assign bus.parity_err = r_parity_err;
`else
  assign bus.parity_err = w_perr;
`endif

  assign bus.ram_data_bus_in = r_rdata;
  assign bus.rd_valid        = r_rd_valid;
  assign bus.ready           = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_cpu_data_ram.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_data_ram
// Description : Scoreboard bench for cpu_data_ram (reads queued, monitor pops).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_data_ram;
  localparam int AW = 8;
  localparam int DW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cpu_data_ram_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  cpu_data_ram #(
    .ADDR_W(AW), .DATA_W(DW), .CLEAR_VALUE(0), .CLEAR_ON_RESET(1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every rd_valid pulse must match the oldest outstanding read.
  always @(negedge clk) begin
    if (rst_n && bus.rd_valid !== 1'b0) begin
      if (exp_q.size() == 0) begin
        chk("rd_valid_unexpected", {31'd0, bus.rd_valid}, 32'd0);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        chk("read_data", {28'd0, bus.ram_data_bus_in}, {28'd0, e});
      end
    end
  end

  task automatic idle(input int n);
    bus.ram_EN = 1'b0;
    bus.ram_RW = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.ram_EN           = 1'b1;
    bus.ram_RW           = 1'b1;
    bus.ram_address_bus  = a;
    bus.ram_data_bus_out = d;
    @(posedge clk);
    #1;
    bus.ram_EN = 1'b0;
    bus.ram_RW = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] e);
    exp_q.push_back(e);
    bus.ram_EN          = 1'b1;
    bus.ram_RW          = 1'b0;
    bus.ram_address_bus = a;
    @(posedge clk);
    #1;
    bus.ram_EN = 1'b0;
  endtask

  // Called with a read strobe to 0x05 held and rst_n just released.
  task automatic run_clear(input string tag);
    int bad;
    bad = 0;
    for (int i = 1; i <= 256; i++) begin
      @(posedge clk);
      #1;
      if (i < 256 && (bus.ready !== 1'b0 || bus.rd_valid !== 1'b0 ||
                      bus.ram_data_bus_in !== 4'h0)) begin
        bad++;
      end
    end
    chk({tag, "_busy_cycles"}, bad, 0);
    chk({tag, "_ready_after_256"}, {31'd0, bus.ready}, 32'd1);
    chk({tag, "_data_zero"}, {28'd0, bus.ram_data_bus_in}, 32'd0);
    bus.ram_EN = 1'b0;
  endtask

  initial begin
    bus.ram_EN           = 1'b1;
    bus.ram_RW           = 1'b0;
    bus.ram_address_bus  = 8'h05;
    bus.ram_data_bus_out = 4'h0;
    rst_n                = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", {28'd0, bus.ram_data_bus_in}, 32'd0);
    chk("rst_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
    chk("rst_ready", {31'd0, bus.ready}, 32'd0);
    chk("rst_parity_err", {31'd0, bus.parity_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_clear("clear1");

    rd(8'h00, 4'h0);
    rd(8'h7F, 4'h0);
    rd(8'hFF, 4'h0);
    idle(1);

    wr(8'h3C, 4'hA);
    rd(8'h3C, 4'hA);
    chk("wr_rd_valid", {31'd0, bus.rd_valid}, 32'd1);
    chk("wr_rd_data", {28'd0, bus.ram_data_bus_in}, 32'hA);
    idle(2);
    chk("hold_data", {28'd0, bus.ram_data_bus_in}, 32'hA);
    chk("hold_rd_valid", {31'd0, bus.rd_valid}, 32'd0);

    wr(8'h00, 4'h5);
    wr(8'hFF, 4'hF);
    rd(8'h00, 4'h5);
    rd(8'hFF, 4'hF);
    rd(8'h01, 4'h0);
    idle(2);

`ifdef RAM_PARITY_EN
    wr(8'h10, 4'h6);
    chk("parity_before_flip", {31'd0, bus.parity_err}, 32'd0);
    dut.r_mem[16][0] = ~dut.r_mem[16][0];
    rd(8'h10, 4'h7);
    chk("parity_err_set", {31'd0, bus.parity_err}, 32'd1);
    rd(8'h00, 4'h5);
    idle(1);
    chk("parity_err_sticky", {31'd0, bus.parity_err}, 32'd1);
`else
    chk("parity_err_tied", {31'd0, bus.parity_err}, 32'd0);
`endif

    // Async reset while a read result is being presented.
    bus.ram_EN          = 1'b1;
    bus.ram_RW          = 1'b0;
    bus.ram_address_bus = 8'hFF;
    @(posedge clk);
    #1;
    bus.ram_EN = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_data", {28'd0, bus.ram_data_bus_in}, 32'd0);
    chk("async_rst_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
    chk("async_rst_ready", {31'd0, bus.ready}, 32'd0);
    chk("async_rst_parity", {31'd0, bus.parity_err}, 32'd0);

    bus.ram_EN          = 1'b1;
    bus.ram_RW          = 1'b0;
    bus.ram_address_bus = 8'h05;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (128) @(posedge clk);
    #1;
    chk("midclear_ready", {31'd0, bus.ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midclear_rst_ready", {31'd0, bus.ready}, 32'd0);
    chk("midclear_rst_data", {28'd0, bus.ram_data_bus_in}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_clear("clear2");

    rd(8'h3C, 4'h0);
    rd(8'hFF, 4'h0);
    idle(3);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
